// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: store widths, MMIO word offsets, TCTRL bits.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_WORD = 2'b01,
    MW_HALF = 2'b10,
    MW_BYTE = 2'b11
  } mw_e;

  localparam logic [4:0] OFF_LED   = 5'h00;
  localparam logic [4:0] OFF_CYCLE = 5'h04;
  localparam logic [4:0] OFF_TCMP  = 5'h08;
  localparam logic [4:0] OFF_TCTRL = 5'h0C;
  localparam logic [4:0] OFF_TCNT  = 5'h10;

  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_PEND = 1;
  localparam int TCTRL_IE   = 2;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-port bundle: address, store data and strobe from the core, combinational read word back.
interface dmem_responder_if;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [1:0]  MemWrite;
  logic [31:0] readdata;

  modport master (output addr, output writedata, output MemWrite, input readdata);
  modport slave  (input addr, input writedata, input MemWrite, output readdata);
endinterface

// File: rtl/dmem_responder_timer.sv
// CYCLE counter plus compare timer (TCMP/TCNT/TCTRL) and its interrupt level; wr_* is a decoded MMIO word write.
module dmem_timer
  import dmem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_off,
  input  logic [31:0] wr_dat,
  output logic [31:0] cycle,
  output logic [31:0] tcmp,
  output logic [31:0] tcnt,
  output logic [2:0]  tctrl,
  output logic        irq
);

  logic en, pend, ie;
  logic match;

  // Compare uses the registered TCMP, so a TCMP write only affects the next cycle.
  assign match = en && (tcnt == tcmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle <= '0;
      tcmp  <= '0;
      tcnt  <= '0;
      en    <= 1'b0;
      pend  <= 1'b0;
      ie    <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (wr_en && wr_off == OFF_TCMP) tcmp <= wr_dat;
      if (wr_en && wr_off == OFF_TCNT) tcnt <= wr_dat;
      else if (match)                  tcnt <= '0;
      else if (en)                     tcnt <= tcnt + 32'd1;
      if (wr_en && wr_off == OFF_TCTRL) begin
        en <= wr_dat[TCTRL_EN];
        ie <= wr_dat[TCTRL_IE];
      end
      // A match in the same cycle as a W1C wins, so no pending event is lost.
      if (match)                                                pend <= 1'b1;
      else if (wr_en && wr_off == OFF_TCTRL && wr_dat[TCTRL_PEND]) pend <= 1'b0;
    end
  end

  assign tctrl = {ie, pend, en};
  assign irq   = pend & ie;

endmodule

// File: rtl/dmem_responder.sv
// Data-side responder: word RAM with byte/half/word stores and an MMIO window (LED, CYCLE, timer).
// Optional sticky access-error flag under DMEM_ACCESS_ERR_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_7F00,
  parameter int          LED_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic [LED_W-1:0]  led,
  output logic              irq
`ifdef DMEM_ACCESS_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [AW-1:0]    idx;
  logic             ram_hit, mmio_hit, mmio_we;
  logic [4:0]       off;
  mw_e              mw;
  logic [3:0]       be;
  logic [31:0]      wdat;
  logic [31:0]      rdata;
  logic [LED_W-1:0] led_q;
  logic [31:0]      cycle, tcmp, tcnt;
  logic [2:0]       tctrl;

  assign mw       = mw_e'(bus.MemWrite);
  assign idx      = bus.addr[AW+1:2];
  assign ram_hit  = bus.addr < RAM_BYTES;
  assign mmio_hit = bus.addr[31:5] == MMIO_BASE[31:5];
  assign off      = {bus.addr[4:2], 2'b00};
  assign mmio_we  = mmio_hit && (mw == MW_WORD);

  // Sub-word data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be   = 4'b0000;
    wdat = bus.writedata;
    case (mw)
      MW_WORD: be = 4'b1111;
      MW_HALF: begin
        be   = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{bus.writedata[15:0]}};
      end
      MW_BYTE: begin
        be   = 4'b0001 << bus.addr[1:0];
        wdat = {4{bus.writedata[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  // No reset on the array; a store coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             led_q <= '0;
    else if (mmio_we && off == OFF_LED)  led_q <= bus.writedata[LED_W-1:0];
  end

  dmem_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (mmio_we),
    .wr_off (off),
    .wr_dat (bus.writedata),
    .cycle  (cycle),
    .tcmp   (tcmp),
    .tcnt   (tcnt),
    .tctrl  (tctrl),
    .irq    (irq)
  );

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = mem[idx];
    end else if (mmio_hit) begin
      case (off)
        OFF_LED:   rdata = 32'(led_q);
        OFF_CYCLE: rdata = cycle;
        OFF_TCMP:  rdata = tcmp;
        OFF_TCTRL: rdata = {29'd0, tctrl};
        OFF_TCNT:  rdata = tcnt;
        default:   rdata = '0;
      endcase
    end
  end

  assign bus.readdata = rdata;
  assign led          = led_q;

`ifdef DMEM_ACCESS_ERR_EN
  logic err_q, err_set;

  always_comb begin
    err_set = ((mw == MW_WORD) && (bus.addr[1:0] != 2'b00))
           || ((mw == MW_HALF) && bus.addr[0])
           || (!ram_hit && !mmio_hit && (mw != MW_NONE))
           || (mmio_hit && ((mw == MW_HALF) || (mw == MW_BYTE)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-level reference model, plus directed scenarios.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int          DEPTH  = 1024;
  localparam logic [31:0] MB     = 32'h0000_7F00;
  localparam int          LW     = 16;
  localparam logic [31:0] IDLE_A = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  logic [LW-1:0] led;
  logic          irq;
`ifdef DMEM_ACCESS_ERR_EN
  logic          err;
  bit            m_err;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB), .LED_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led),
    .irq (irq)
`ifdef DMEM_ACCESS_ERR_EN
    ,
    .err (err)
`endif
  );

  // Reference model: memory as plain bytes, registers as named variables.
  logic [7:0]    m_mem [DEPTH*4];
  logic [LW-1:0] m_led;
  logic [31:0]   m_cycle, m_tcmp, m_tcnt;
  bit            m_en, m_pend, m_ie;

  typedef struct {
    logic [31:0]   rd;
    logic [LW-1:0] led;
    bit            irq;
    bit            err;
  } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= MB) && (a < MB + 32'd32);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int unsigned b;
    logic [31:0] w;
    w = '0;
    if (a < 32'(DEPTH*4)) begin
      b = a & ~32'd3;
      w = {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
    end else if (in_mmio(a)) begin
      case ((a - MB) >> 2)
        32'd0:   w = 32'(m_led);
        32'd1:   w = m_cycle;
        32'd2:   w = m_tcmp;
        32'd3:   w = {29'd0, m_ie, m_pend, m_en};
        32'd4:   w = m_tcnt;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  task automatic m_reset();
    m_led = '0; m_cycle = '0; m_tcmp = '0; m_tcnt = '0;
    m_en = 0; m_pend = 0; m_ie = 0;
`ifdef DMEM_ACCESS_ERR_EN
    m_err = 0;
`endif
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic m_commit(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] mw);
    bit          ram, mm, wr_mm, match, n_pend;
    int unsigned ai, o;
    logic [31:0] n_tcnt;
    ram   = a < 32'(DEPTH*4);
    mm    = in_mmio(a);
    o     = mm ? (a - MB) >> 2 : 0;
    wr_mm = mm && (mw == MW_WORD);
    ai    = a;
`ifdef DMEM_ACCESS_ERR_EN
    if ((mw == MW_WORD && a[1:0] != 0) || (mw == MW_HALF && a[0]) ||
        (!ram && !mm && mw != MW_NONE) || (mm && (mw == MW_HALF || mw == MW_BYTE)))
      m_err = 1;
`endif
    if (ram) begin
      if (mw == MW_WORD)
        for (int i = 0; i < 4; i++) m_mem[(ai & ~32'd3) + i] = wd[8*i +: 8];
      else if (mw == MW_HALF) begin
        m_mem[ai & ~32'd1]           = wd[7:0];
        m_mem[(ai & ~32'd1) + 32'd1] = wd[15:8];
      end else if (mw == MW_BYTE)
        m_mem[ai] = wd[7:0];
    end
    match  = m_en && (m_tcnt == m_tcmp);
    n_tcnt = m_tcnt;
    if (m_en) n_tcnt = match ? 32'd0 : m_tcnt + 32'd1;
    if (wr_mm && o == 4) n_tcnt = wd;
    n_pend = m_pend;
    if (wr_mm && o == 3 && wd[1]) n_pend = 0;
    if (match) n_pend = 1;
    if (wr_mm && o == 0) m_led = wd[LW-1:0];
    if (wr_mm && o == 2) m_tcmp = wd;
    if (wr_mm && o == 3) begin m_en = wd[0]; m_ie = wd[2]; end
    m_tcnt  = n_tcnt;
    m_pend  = n_pend;
    m_cycle = m_cycle + 32'd1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] mw);
    bus.addr = a; bus.writedata = wd; bus.MemWrite = mw;
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] mw,
                      input bit commit = 1, input bit check = 1);
    exp_t e;
    @(posedge clk);
    #1;
    drive(a, wd, mw);
    if (check) begin
      e.rd  = m_read(a);
      e.led = m_led;
      e.irq = m_pend & m_ie;
`ifdef DMEM_ACCESS_ERR_EN
      e.err = m_err;
`else
      e.err = 0;
`endif
      exp_q.push_back(e);
    end
    if (commit) m_commit(a, wd, mw);
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(IDLE_A, '0, MW_NONE);
    m_commit(IDLE_A, '0, MW_NONE);
  endtask

  task automatic do_reset(input bit abort_store);
    if (abort_store) #5;
    else begin @(posedge clk); #1; end
    rst = 1'b1;
    m_reset();
    #1;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    drive(IDLE_A, '0, MW_NONE);
    release_rst();
  endtask

  task automatic seek_match();
    bit found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_en && m_tcnt == m_tcmp) found = 1;
      else step(MB + 32'h10, '0, MW_NONE);
    end
    if (!found) begin
      n_chk++;
      $display("FAIL seek_match: timer match not reached within 40 cycles");
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_readdata", bus.readdata, e.rd);
      chk("sb_led", 32'(led), 32'(e.led));
      chk("sb_irq", 32'(irq), 32'(e.irq));
`ifdef DMEM_ACCESS_ERR_EN
      chk("sb_err", 32'(err), 32'(e.err));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  mw;
    int          r;

    drive(IDLE_A, '0, MW_NONE);
    m_reset();
    #1;
    chk("init_led", 32'(led), 32'd0);
    chk("init_irq", 32'(irq), 32'd0);
`ifdef DMEM_ACCESS_ERR_EN
    chk("init_err", 32'(err), 32'd0);
`endif
    release_rst();

    // CYCLE after 100 post-reset edges.
    repeat (99) step(IDLE_A, '0, MW_NONE);
    step(MB + 32'h4, '0, MW_NONE);
    @(negedge clk); chk("cycle_100", bus.readdata, 32'd100);

    step(MB, 32'h0003_ABCD, MW_WORD);
    step(MB, '0, MW_NONE);
    @(negedge clk);
    chk("led_read", bus.readdata, 32'h0000_ABCD);
    chk("led_pin", 32'(led), 32'h0000_ABCD);

    for (int i = 0; i < DEPTH; i++) step(32'(i * 4), '0, MW_WORD, 1, 0);

    step(32'h10, 32'hDEAD_BEEF, MW_WORD);
    step(32'h13, 32'h0000_00AA, MW_BYTE);
    step(32'h10, '0, MW_NONE);
    @(negedge clk); chk("byte_store", bus.readdata, 32'hAAAD_BEEF);
    step(32'h12, 32'h0000_1234, MW_HALF);
    step(32'h10, '0, MW_NONE);
    @(negedge clk); chk("half_store", bus.readdata, 32'h1234_BEEF);

    step(32'h20, 32'h0000_0055, MW_BYTE);
    @(negedge clk); chk("same_cycle_old", bus.readdata, 32'h0);
    step(32'h20, '0, MW_NONE);
    @(negedge clk); chk("next_cycle_new", bus.readdata, 32'h0000_0055);

    step(MB + 32'h8, 32'd5, MW_WORD);
    step(MB + 32'hC, 32'b101, MW_WORD);
    repeat (6) step(MB + 32'hC, '0, MW_NONE);
    @(negedge clk);
    chk("tctrl_before_match", bus.readdata, 32'b101);
    chk("irq_before_match", 32'(irq), 32'd0);
    step(MB + 32'h10, '0, MW_NONE);
    @(negedge clk);
    chk("tcnt_reload", bus.readdata, 32'd0);
    chk("irq_on_match", 32'(irq), 32'd1);
    step(MB + 32'hC, '0, MW_NONE);
    @(negedge clk); chk("tctrl_pend", bus.readdata, 32'b111);
    step(MB + 32'hC, 32'b111, MW_WORD);
    step(MB + 32'hC, '0, MW_NONE);
    @(negedge clk);
    chk("tctrl_w1c", bus.readdata, 32'b101);
    chk("irq_w1c", 32'(irq), 32'd0);

    seek_match();
    step(MB + 32'hC, 32'b111, MW_WORD);
    step(MB + 32'hC, '0, MW_NONE);
    @(negedge clk); chk("match_beats_w1c", bus.readdata, 32'b111);

    seek_match();
    step(MB + 32'h10, 32'd3, MW_WORD);
    step(MB + 32'h10, '0, MW_NONE);
    @(negedge clk); chk("tcnt_write_wins", bus.readdata, 32'd3);

    // Reset lands between the store's drive and its commit edge.
    step(32'h40, 32'hCAFE_F00D, MW_WORD, 0, 1);
    do_reset(1);
    step(MB + 32'hC, '0, MW_NONE);
    @(negedge clk); chk("rst_tctrl", bus.readdata, 32'd0);
    step(32'h40, '0, MW_NONE);
    @(negedge clk); chk("rst_store_dropped", bus.readdata, 32'd0);
    step(MB, '0, MW_NONE);
    @(negedge clk); chk("rst_led_reg", bus.readdata, 32'd0);

`ifdef DMEM_ACCESS_ERR_EN
    step(32'h11, 32'h89AB_CDEF, MW_WORD);
    step(32'h10, '0, MW_NONE);
    @(negedge clk);
    chk("misaligned_data", bus.readdata, 32'h89AB_CDEF);
    chk("misaligned_err", 32'(err), 32'd1);
`endif

    for (int n = 0; n < 1500; n++) begin
      r  = $urandom_range(0, 9);
      wd = $urandom;
      mw = 2'($urandom_range(0, 3));
      if (r <= 4)      a = 32'($urandom_range(0, 63));
      else if (r == 5) a = 32'($urandom_range(0, DEPTH*4 - 1));
      else if (r <= 8) begin
        a = MB + 32'($urandom_range(0, 31));
        if (((a - MB) >> 2) == 2 || ((a - MB) >> 2) == 4) wd = 32'($urandom_range(0, 12));
      end else         a = 32'($urandom_range(32'h1000, 32'h7EFF));
      if (n == 750) do_reset(0);
      step(a, wd, mw);
    end

    step(IDLE_A, '0, MW_NONE);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
